// File: rtl/status_irq_ctrl.sv
// MCU-side status controller: snapshot reads, W1C clear handshake to the monitor,
// and a level/pulse interrupt built from the enabled sticky flags.
module status_irq_ctrl #(
  parameter int PULSE_LEN = 4
) (
  input  logic        HF_CLK,
  input  logic        NRST_sync,
  input  logic [13:0] status,
  input  logic [13:0] irq_en,
  input  logic        irq_mode,
  input  logic        rd_req,
  input  logic        rd_clr,
  input  logic        wr_req,
  input  logic [13:0] wr_mask,
  output logic [13:0] rd_data,
  output logic        rd_valid,
  output logic        status_clr_pulse,
  output logic [13:0] status_clr_mask,
  output logic        busy,
  output logic        req_drop,
  output logic        IRQ
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    CLR,
    WAIT
  } state_t;

  state_t          state;
  logic            rd_clr_q;
  logic            pend;
  logic            pend_q;
  logic [CW-1:0]   pulse_cnt;

  // Requests are accepted only in IDLE; anything arriving later is dropped and flagged.
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state            <= IDLE;
      rd_clr_q         <= 1'b0;
      rd_data          <= '0;
      rd_valid         <= 1'b0;
      status_clr_pulse <= 1'b0;
      status_clr_mask  <= '0;
      busy             <= 1'b0;
      req_drop         <= 1'b0;
    end else begin
      rd_valid         <= 1'b0;
      status_clr_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            rd_data  <= status;
            rd_clr_q <= rd_clr;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SNAP;
            if (wr_req) req_drop <= 1'b1;
          end else if (wr_req) begin
            status_clr_mask  <= {1'b0, wr_mask[12:0]};
            status_clr_pulse <= 1'b1;
            busy             <= 1'b1;
            state            <= CLR;
            if (wr_mask[13]) req_drop <= 1'b0;
          end
        end
        SNAP: begin
          if (rd_clr_q) begin
            status_clr_mask  <= {1'b0, rd_data[12:0]};
            status_clr_pulse <= 1'b1;
            state            <= CLR;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CLR: begin
          state <= WAIT;
        end
        WAIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      if ((state != IDLE) && (rd_req || wr_req)) req_drop <= 1'b1;
    end
  end

  // ENSAMP (bit 13) never contributes; the zero pad keeps every enable bit referenced.
  assign pend = |({1'b0, status[12:0]} & irq_en);

  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      pend_q    <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      pend_q <= pend;
      if (!irq_mode) begin
        pulse_cnt <= '0;
      end else if (pend && !pend_q && (pulse_cnt == '0)) begin
        pulse_cnt <= CW'(PULSE_LEN);
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - CW'(1);
      end
    end
  end

  assign IRQ = irq_mode ? (pulse_cnt != '0) : pend_q;

endmodule

// File: tb/tb_status_irq_ctrl.sv
// Directed and random checks of status_irq_ctrl against a cycle-schedule reference model.
module tb_status_irq_ctrl;

  localparam int PULSE_LEN = 4;

  logic        HF_CLK = 1'b0;
  logic        NRST_sync = 1'b1;
  logic [13:0] status = '0;
  logic [13:0] irq_en = '0;
  logic        irq_mode = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_clr = 1'b0;
  logic        wr_req = 1'b0;
  logic [13:0] wr_mask = '0;
  logic [13:0] rd_data;
  logic        rd_valid;
  logic        status_clr_pulse;
  logic [13:0] status_clr_mask;
  logic        busy;
  logic        req_drop;
  logic        IRQ;

  int assert_count = 0;
  int fail_count = 0;

  // Reference model: events are scheduled as absolute cycle numbers.
  int          cyc;
  int          busy_left;
  int          valid_cyc;
  int          pulse_cyc;
  int          mask_cyc;
  int          pulse_end;
  logic [13:0] m_rd_data;
  logic [13:0] m_mask;
  logic [13:0] pending_mask;
  logic        m_drop;
  logic        pend_last;
  logic        m_irq;

  status_irq_ctrl #(.PULSE_LEN(PULSE_LEN)) dut (
    .HF_CLK(HF_CLK),
    .NRST_sync(NRST_sync),
    .status(status),
    .irq_en(irq_en),
    .irq_mode(irq_mode),
    .rd_req(rd_req),
    .rd_clr(rd_clr),
    .wr_req(wr_req),
    .wr_mask(wr_mask),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .status_clr_pulse(status_clr_pulse),
    .status_clr_mask(status_clr_mask),
    .busy(busy),
    .req_drop(req_drop),
    .IRQ(IRQ)
  );

  always #5 HF_CLK = ~HF_CLK;

  task automatic check_output(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc          = 0;
    busy_left    = 0;
    valid_cyc    = -10;
    pulse_cyc    = -10;
    mask_cyc     = -10;
    pulse_end    = 0;
    m_rd_data    = '0;
    m_mask       = '0;
    pending_mask = '0;
    m_drop       = 1'b0;
    pend_last    = 1'b0;
    m_irq        = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs that edge sampled.
  task automatic model_edge();
    logic pend_now;
    pend_now = |(status[12:0] & irq_en[12:0]);
    if (busy_left == 0) begin
      if (rd_req) begin
        m_rd_data = status;
        valid_cyc = cyc + 1;
        if (rd_clr) begin
          pulse_cyc    = cyc + 2;
          mask_cyc     = cyc + 2;
          pending_mask = status & 14'h1FFF;
          busy_left    = 3;
        end else begin
          busy_left = 1;
        end
        if (wr_req) m_drop = 1'b1;
      end else if (wr_req) begin
        pulse_cyc    = cyc + 1;
        mask_cyc     = cyc + 1;
        pending_mask = wr_mask & 14'h1FFF;
        busy_left    = 2;
        if (wr_mask[13]) m_drop = 1'b0;
      end
    end else begin
      if (rd_req || wr_req) m_drop = 1'b1;
      busy_left--;
    end
    if (!irq_mode) pulse_end = 0;
    else if (pend_now && !pend_last && !(cyc < pulse_end)) pulse_end = cyc + 1 + PULSE_LEN;
    pend_last = pend_now;
    cyc++;
    if (cyc == mask_cyc) m_mask = pending_mask;
    m_irq = irq_mode ? (cyc < pulse_end) : pend_now;
  endtask

  task automatic apply_stimulus();
    @(posedge HF_CLK);
    #1;
    model_edge();
    check_output("rd_valid", rd_valid, (cyc == valid_cyc));
    check_output("rd_data", rd_data, m_rd_data);
    check_output("clr_pulse", status_clr_pulse, (cyc == pulse_cyc));
    check_output("clr_mask", status_clr_mask, m_mask);
    check_output("busy", busy, (busy_left > 0));
    check_output("req_drop", req_drop, m_drop);
    check_output("irq", IRQ, m_irq);
  endtask

  task automatic request(input logic rd, input logic clr, input logic wr, input logic [13:0] wm);
    rd_req  = rd;
    rd_clr  = clr;
    wr_req  = wr;
    wr_mask = wm;
    apply_stimulus();
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 NRST_sync = 1'b0;
    #1;
    check_output("reset_rd_data", rd_data, 14'h0);
    check_output("reset_busy", busy, 14'h0);
    check_output("reset_irq", IRQ, 14'h0);
    @(negedge HF_CLK);
    NRST_sync = 1'b1;
    apply_stimulus();

    $display("[TB] read with clear");
    status = 14'h2105;
    request(1'b1, 1'b1, 1'b0, 14'h0);
    check_output("rdclr_data", rd_data, 14'h2105);
    check_output("rdclr_valid", rd_valid, 14'h1);
    apply_stimulus();
    check_output("rdclr_pulse", status_clr_pulse, 14'h1);
    check_output("rdclr_mask", status_clr_mask, 14'h0105);
    apply_stimulus();
    check_output("rdclr_wait_busy", busy, 14'h1);
    apply_stimulus();
    check_output("rdclr_busy_low", busy, 14'h0);

    $display("[TB] collision");
    status = 14'h0042;
    request(1'b1, 1'b0, 1'b1, 14'h3FFF);
    check_output("coll_valid", rd_valid, 14'h1);
    check_output("coll_drop", req_drop, 14'h1);
    check_output("coll_no_pulse", status_clr_pulse, 14'h0);
    request(1'b1, 1'b0, 1'b0, 14'h0);
    check_output("coll_second_dropped", rd_valid, 14'h0);
    check_output("coll_rd_data", rd_data, 14'h0042);
    apply_stimulus();

    $display("[TB] W1C write");
    request(1'b0, 1'b0, 1'b1, 14'h3FFF);
    check_output("w1c_pulse", status_clr_pulse, 14'h1);
    check_output("w1c_mask", status_clr_mask, 14'h1FFF);
    check_output("w1c_drop_clear", req_drop, 14'h0);
    apply_stimulus();
    apply_stimulus();
    check_output("w1c_busy_low", busy, 14'h0);
    check_output("w1c_mask_hold", status_clr_mask, 14'h1FFF);
    request(1'b0, 1'b0, 1'b1, 14'h0000);
    check_output("w1c_zero_pulse", status_clr_pulse, 14'h1);
    check_output("w1c_zero_mask", status_clr_mask, 14'h0);
    apply_stimulus();
    apply_stimulus();

    $display("[TB] level IRQ");
    irq_mode = 1'b0;
    irq_en   = 14'h0100;
    status   = 14'h0000;
    apply_stimulus();
    status = 14'h0100;
    apply_stimulus();
    check_output("lvl_rise", IRQ, 14'h1);
    status = 14'h2100;
    apply_stimulus();
    check_output("lvl_ensamp_hi", IRQ, 14'h1);
    status = 14'h0000;
    apply_stimulus();
    check_output("lvl_fall", IRQ, 14'h0);
    status = 14'h2000;
    apply_stimulus();
    check_output("lvl_ensamp_only", IRQ, 14'h0);

    $display("[TB] pulse IRQ");
    irq_mode = 1'b1;
    irq_en   = 14'h0003;
    status   = 14'h0000;
    apply_stimulus();
    status = 14'h0001;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) status = 14'h0003;
      apply_stimulus();
      check_output("pulse_first", IRQ, (i < PULSE_LEN) ? 14'h1 : 14'h0);
    end
    status = 14'h0000;
    apply_stimulus();
    apply_stimulus();
    status = 14'h0002;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus();
      check_output("pulse_again", IRQ, (i < PULSE_LEN) ? 14'h1 : 14'h0);
    end
    status = 14'h0000;
    apply_stimulus();
    status = 14'h0001;
    apply_stimulus();
    irq_mode = 1'b0;
    apply_stimulus();
    check_output("mode_switch_level", IRQ, 14'h1);
    irq_mode = 1'b1;
    apply_stimulus();
    check_output("mode_switch_no_pulse", IRQ, 14'h0);

    $display("[TB] reset during CLR");
    request(1'b0, 1'b0, 1'b1, 14'h00FF);
    #2 NRST_sync = 1'b0;
    #1;
    check_output("rst_pulse", status_clr_pulse, 14'h0);
    check_output("rst_mask", status_clr_mask, 14'h0);
    check_output("rst_busy", busy, 14'h0);
    check_output("rst_irq", IRQ, 14'h0);
    check_output("rst_rd_data", rd_data, 14'h0);
    model_reset();
    @(posedge HF_CLK);
    #2 NRST_sync = 1'b1;
    status = 14'h1234;
    request(1'b1, 1'b0, 1'b0, 14'h0);
    check_output("rst_then_read", rd_data, 14'h1234);
    apply_stimulus();

    $display("[TB] random traffic");
    irq_en = 14'h0021;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) status = 14'($urandom);
      if ($urandom_range(0, 99) == 0) irq_en = 14'($urandom) & 14'($urandom);
      if ($urandom_range(0, 39) == 0) irq_mode = ~irq_mode;
      rd_clr  = 1'($urandom);
      wr_mask = 14'($urandom);
      rd_req  = ($urandom_range(0, 3) == 0);
      wr_req  = ($urandom_range(0, 4) == 0);
      apply_stimulus();
    end
    rd_req = 1'b0;
    wr_req = 1'b0;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
